spi_slave: RTL

SPI mode-0 responder that receives bytes from the SoC's SPI master (spi_clk/spi_mosi/spi_miso/spi_cs) and returns bytes from a CPU-loaded holding register. It oversamples the SPI pins in the system clock domain and presents a simple load/ack register interface to the picoRV32 bus glue. It serves as an on-chip loopback target for the SPI master and as the device-side peripheral when the core is used as an SPI slave.

---
 rtl/spi_slave.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 slave that oversamples the SPI pins in the system clock domain.
// A CPU-side holding register supplies transmit bytes; received bytes are latched with valid/overrun flags.
module spi_slave #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_TX     = 8'hFF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  spi_clk,
    input  logic                  spi_cs,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    output logic                  rx_overrun,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES:0]   settle;
    logic                   armed;
    logic                   sclk_d;
    logic                   cs_d;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_fall;
    logic                   cs_rise;

    logic [0:0]             state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0]  tx_shift;
    logic [DATA_WIDTH-2:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  hold_data;
    logic                   hold_full;

    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   byte_start;
    logic                   byte_done;
    logic [DATA_WIDTH-1:0]  reload_byte;
    logic [DATA_WIDTH-1:0]  rx_next;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    // A select that is already low when reset releases must not open a frame:
    // chip select has to be seen high once the synchronizer has flushed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            settle    <= '0;
            armed     <= 1'b0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
        end else begin
            settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
            if (settle[SYNC_STAGES] && cs_s) begin
                armed <= 1'b1;
            end
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            sclk_rise <= sclk_s & ~sclk_d;
            sclk_fall <= ~sclk_s & sclk_d;
            cs_fall   <= armed & cs_d & ~cs_s;
            cs_rise   <= cs_s & ~cs_d;
        end
    end

    assign reload_byte = hold_full ? hold_data : IDLE_TX;
    assign rx_next     = {rx_shift, mosi_s};
    assign byte_start  = !cs_rise && (cs_fall ||
                         (state == ACTIVE && sclk_fall && bit_cnt == '0));
    assign byte_done   = !cs_rise && state == ACTIVE && sclk_rise && bit_cnt == LAST_BIT;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
        end else if (cs_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else if (cs_fall) begin
            state    <= ACTIVE;
            bit_cnt  <= '0;
            tx_shift <= reload_byte;
        end else if (state == ACTIVE) begin
            if (sclk_rise) begin
                rx_shift <= rx_next[DATA_WIDTH-2:0];
                if (byte_done) begin
                    bit_cnt <= '0;
                    rx_data <= rx_next;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (sclk_fall) begin
                if (bit_cnt == '0) begin
                    tx_shift <= reload_byte;
                end else begin
                    tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    // A completing byte beats a simultaneous acknowledge; the ack still
    // clears any overrun, since the old byte was consumed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (byte_done) begin
            rx_valid   <= 1'b1;
            rx_overrun <= rx_ack ? 1'b0 : (rx_overrun | rx_valid);
        end else if (rx_ack) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (byte_start) begin
            hold_full <= tx_load;
            if (tx_load) begin
                hold_data <= tx_data;
            end
        end else if (tx_load && !hold_full) begin
            hold_data <= tx_data;
            hold_full <= 1'b1;
        end
    end

    assign spi_miso = (state == ACTIVE) & tx_shift[DATA_WIDTH-1];
    assign tx_ready = ~hold_full;
    assign busy     = ~cs_s;

endmodule
